// File: rtl/mii_net_pkg.sv
// Shared types and CRC-32 helpers for the MII TX frame path.
package mii_net_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_fcs_state_t;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  // Entry of the reflected byte-wise CRC-32 lookup table.
  function automatic logic [31:0] crc32_tbl(input logic [7:0] idx);
    logic [31:0] c;
    c = {24'h000000, idx};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_net_crc32_byte.sv
// Byte-wide reflected CRC-32 register; en folds a byte, init reloads all-ones.
module mii_net_crc32_byte
  import mii_net_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (i_en) begin
      crc_d = crc32_tbl(crc_q[7:0] ^ i_byte) ^ (crc_q >> 8);
    end else if (i_init) begin
      crc_d = CRC32_INIT;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) crc_q <= CRC32_INIT;
    else            crc_q <= crc_d;
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/mii_net_tx_fcs.sv
// TX frame sequencer: forwards payload, appends CRC-32 FCS, enforces IFG.
// Optional zero padding to MIN_FRAME when MII_NET_TX_PAD_EN is defined.
module mii_net_tx_fcs
  import mii_net_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned MIN_FRAME  = 60
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [7:0]       i_s_data,
  input  logic             i_s_valid,
  input  logic             i_s_last,
  output logic             o_s_ready,
  output logic [7:0]       o_m_data,
  output logic             o_m_valid,
  output logic             o_m_last,
  input  logic             i_m_ready,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [LEN_W-1:0] o_frame_len
);

  localparam int unsigned      IFG_W   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  tx_fcs_state_t    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, frame_len_q, frame_len_d, len_inc;
  logic [LEN_W:0]   len_plus_fcs;
  logic [IFG_W-1:0] ifg_q, ifg_d;
  logic [1:0]       idx_q, idx_d;
  logic             done_q, done_d, run_q;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic             load_ok, s_ready, s_hs, last_hs;
  logic             load, load_last, crc_en, crc_init;
  logic [7:0]       load_data, crc_byte;
  logic [31:0]      crc, fcs;
  tx_fcs_state_t    tail_state;

  assign load_ok      = !m_valid_q | i_m_ready;
  assign s_hs         = i_s_valid & s_ready;
  assign last_hs      = m_valid_q & m_last_q & i_m_ready;
  assign len_inc      = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);
  assign len_plus_fcs = {1'b0, len_q} + (LEN_W+1)'(4);
  assign fcs          = ~crc;

`ifdef MII_NET_TX_PAD_EN
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME);
  logic [LEN_W-1:0] len_next;
  assign len_next   = (state_q == IDLE) ? LEN_W'(1) : len_inc;
  assign tail_state = (len_next < MIN_LEN) ? PAD : FCS;
`else
  assign tail_state = FCS;
`endif

  mii_net_crc32_byte u_crc (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_init    (crc_init),
    .i_en      (crc_en),
    .i_byte    (crc_byte),
    .o_crc     (crc)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      frame_len_q <= '0;
      ifg_q       <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      frame_len_q <= frame_len_d;
      ifg_q       <= ifg_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      run_q       <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    frame_len_d = frame_len_q;
    ifg_d       = ifg_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE, DATA: begin
        if (s_hs) begin
          len_d = (state_q == IDLE) ? LEN_W'(1) : len_inc;
          if (i_s_last) begin
            state_d = tail_state;
            idx_d   = '0;
          end else begin
            state_d = DATA;
          end
        end
      end
`ifdef MII_NET_TX_PAD_EN
      PAD: begin
        if (load_ok) begin
          len_d = len_inc;
          if (len_inc >= MIN_LEN) begin
            state_d = FCS;
            idx_d   = '0;
          end
        end
      end
`endif
      FCS: begin
        // The last FCS byte is only retired by its handshake, never overwritten.
        if (last_hs) begin
          done_d      = 1'b1;
          frame_len_d = len_plus_fcs[LEN_W] ? LEN_MAX : len_plus_fcs[LEN_W-1:0];
          ifg_d       = IFG_W'(IFG_CYCLES - 1);
          state_d     = IFG;
        end else if (load_ok) begin
          idx_d = idx_q + 2'd1;
        end
      end
      IFG: begin
        if (ifg_q == '0) state_d = IDLE;
        else             ifg_d   = ifg_q - IFG_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = 1'b0;
    load      = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    crc_en    = 1'b0;
    crc_init  = 1'b0;
    crc_byte  = i_s_data;
    unique case (state_q)
      IDLE, DATA: begin
        // run_q keeps o_s_ready low while reset is held.
        s_ready   = load_ok & run_q;
        load      = i_s_valid & s_ready;
        load_data = i_s_data;
        crc_en    = load;
      end
      PAD: begin
        load     = load_ok;
        crc_en   = load_ok;
        crc_byte = '0;
      end
      FCS: begin
        load      = load_ok & !(m_valid_q & m_last_q);
        load_data = fcs[{idx_q, 3'b000} +: 8];
        load_last = (idx_q == 2'd3);
      end
      IFG:     crc_init = 1'b1;
      default: crc_init = 1'b1;
    endcase
  end

  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    if (load) begin
      m_data_d  = load_data;
      m_valid_d = 1'b1;
      m_last_d  = load_last;
    end else if (i_m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  assign o_s_ready    = s_ready;
  assign o_m_data     = m_data_q;
  assign o_m_valid    = m_valid_q;
  assign o_m_last     = m_last_q;
  assign o_busy       = (state_q != IDLE);
  assign o_frame_done = done_q;
  assign o_frame_len  = frame_len_q;

endmodule

// File: tb/tb_mii_net_tx_fcs.sv
// Self-checking bench for mii_net_tx_fcs: bitwise CRC-32 model plus scoreboard.
module tb_mii_net_tx_fcs;

`ifdef MII_NET_TX_PAD_EN
  localparam int N9 = 64;
  localparam int N1 = 64;
  localparam int N20 = 64;
`else
  localparam int N9 = 13;
  localparam int N1 = 5;
  localparam int N20 = 24;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_ready, s_ready4;
  logic [7:0]  m_data, m_data4;
  logic        m_valid, m_valid4, m_last, m_last4, m_ready;
  logic        busy, busy4, done, done4;
  logic [15:0] flen;
  logic [3:0]  flen4;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  int          exp_len[$];
  int          exp_len4[$];
  logic [7:0]  rx_log[$];
  int          done_cnt = 0;
  bit          rand_rdy = 1'b0;

  always #5 clk = ~clk;

  mii_net_tx_fcs #(.IFG_CYCLES(12), .LEN_W(16), .MIN_FRAME(60)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_s_data(s_data), .i_s_valid(s_valid),
    .i_s_last(s_last), .o_s_ready(s_ready), .o_m_data(m_data), .o_m_valid(m_valid),
    .o_m_last(m_last), .i_m_ready(m_ready), .o_busy(busy), .o_frame_done(done),
    .o_frame_len(flen)
  );

  mii_net_tx_fcs #(.IFG_CYCLES(12), .LEN_W(4), .MIN_FRAME(1)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_s_data(s_data), .i_s_valid(s_valid),
    .i_s_last(s_last), .o_s_ready(s_ready4), .o_m_data(m_data4), .o_m_valid(m_valid4),
    .o_m_last(m_last4), .i_m_ready(m_ready), .o_busy(busy4), .o_frame_done(done4),
    .o_frame_len(flen4)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Plain bit-serial CRC-32 (reflected), returns the inverted value sent as FCS.
  function automatic logic [31:0] sw_fcs(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h000000, b[i]};
      for (int unsigned k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic model_push(input logic [7:0] pl[$]);
    logic [7:0]  fr[$];
    logic [31:0] f;
    fr = pl;
`ifdef MII_NET_TX_PAD_EN
    while (fr.size() < 60) fr.push_back(8'h00);
`endif
    f = sw_fcs(fr);
    for (int unsigned k = 0; k < 4; k++) fr.push_back(f[8*k +: 8]);
    for (int unsigned i = 0; i < fr.size(); i++) exp_q.push_back({(i == fr.size() - 1), fr[i]});
    exp_len.push_back(fr.size() > 65535 ? 65535 : fr.size());
    exp_len4.push_back(fr.size() > 15 ? 15 : fr.size());
  endtask

  // Called at posedge+1; returns at posedge+1 right after the byte's handshake.
  task automatic drive_byte(input logic [7:0] b, input bit last);
    int w;
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    w = 0;
    @(negedge clk);
    while (!s_ready) begin
      w++;
      if (w > 5000) begin
        $display("FAIL s_ready_timeout: got 0 expected 1 at %0t", $time);
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send(input logic [7:0] pl[$], input bit gaps);
    model_push(pl);
    for (int unsigned i = 0; i < pl.size(); i++) begin
      drive_byte(pl[i], i == pl.size() - 1);
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_done(input string name);
    int w;
    w = 0;
    @(negedge clk);
    while (!done) begin
      w++;
      if (w > 5000) begin
        chk(name, done, 1);
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_fcs_literal(input string name, input int base);
    logic [31:0] lit;
    lit = 32'hCBF43926;
    for (int unsigned k = 0; k < 4; k++) chk(name, rx_log[base + k], lit[8*k +: 8]);
  endtask

  task automatic check_reset_zero();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frame_len", flen, 0);
    chk("rst4_outputs", {m_valid4, m_data4, m_last4, s_ready4, busy4, done4, flen4}, 0);
  endtask

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Scoreboard compare: sampled on the falling edge, away from the active edge.
  bit         stall = 1'b0;
  logic [7:0] held_data;
  logic       held_last;
  bit         ifg_on = 1'b0;
  int         ifg_cnt = 0;
  logic       prev_done = 1'b0;
  logic [8:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall     = 1'b0;
      ifg_on    = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, held_data);
        chk("hold_last", m_last, held_last);
      end
      stall     = m_valid & !m_ready;
      held_data = m_data;
      held_last = m_last;

      if (ifg_on) begin
        if (!s_ready) begin
          ifg_cnt++;
          chk("busy_in_ifg", busy, 1);
          if (ifg_cnt > 1000) begin
            chk("ifg_bound", s_ready, 1);
            ifg_on = 1'b0;
          end
        end else begin
          chk("ifg_len", ifg_cnt, 12);
          ifg_on = 1'b0;
        end
      end

      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", m_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data", m_data, e[7:0]);
          chk("last", m_last, e[8]);
`ifndef MII_NET_TX_PAD_EN
          chk("valid4", m_valid4, 1);
          chk("data4", m_data4, e[7:0]);
          chk("last4", m_last4, e[8]);
`endif
        end
        rx_log.push_back(m_data);
        if (m_last) begin
          ifg_on  = 1'b1;
          ifg_cnt = 0;
        end
      end

      if (done) begin
        if (prev_done) chk("done_pulse", done, 0);
        if (exp_len.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          chk("frame_len", flen, exp_len.pop_front());
`ifndef MII_NET_TX_PAD_EN
          chk("frame_len4", flen4, exp_len4.pop_front());
`endif
        end
        done_cnt++;
      end
      prev_done = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] s9[$];
    logic [7:0] s1[$];
    logic [7:0] s20[$];
    int         d0;
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    s1 = '{8'hAA};
    for (int unsigned i = 0; i < 20; i++) s20.push_back(8'(8'h40 + i));

    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    #3;
    check_reset_zero();
    chk("model_pin", sw_fcs(s9), 32'hCBF43926);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame with downstream always ready.
    rx_log.delete(); d0 = done_cnt;
    send(s9, 1'b0);
    wait_done("done_basic");
    repeat (3) @(posedge clk); #1;
    chk("nbytes_basic", rx_log.size(), N9);
`ifndef MII_NET_TX_PAD_EN
    check_fcs_literal("fcs_basic", 9);
`endif
    chk("done_count_basic", done_cnt - d0, 1);

    // Same frame, random backpressure and upstream gaps.
    rand_rdy = 1'b1;
    rx_log.delete();
    send(s9, 1'b1);
    wait_done("done_stall");
    rand_rdy = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("nbytes_stall", rx_log.size(), N9);
`ifndef MII_NET_TX_PAD_EN
    check_fcs_literal("fcs_stall", 9);
`endif

    // Back-to-back frames: the IFG check runs in the compare process.
    rx_log.delete(); d0 = done_cnt;
    send(s9, 1'b0);
    send(s9, 1'b0);
    wait_done("done_b2b");
    repeat (3) @(posedge clk); #1;
    chk("nbytes_b2b", rx_log.size(), 2 * N9);
`ifndef MII_NET_TX_PAD_EN
    check_fcs_literal("fcs_b2b_first", 9);
    check_fcs_literal("fcs_b2b_second", 22);
`endif
    chk("done_count_b2b", done_cnt - d0, 2);

    // One-byte frame: padded or not depending on build.
    rx_log.delete();
    send(s1, 1'b0);
    wait_done("done_short");
    repeat (3) @(posedge clk); #1;
    chk("nbytes_short", rx_log.size(), N1);
    chk("len_short", flen, N1);
    chk("short_first", rx_log[0], 8'hAA);

    // Reset after three payload bytes aborts the frame.
    rx_log.delete();
    for (int unsigned i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, s9[i]});
      drive_byte(s9[i], 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_zero();
    exp_q.delete(); exp_len.delete(); exp_len4.delete(); rx_log.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(s9, 1'b0);
    wait_done("done_after_rst");
    repeat (3) @(posedge clk); #1;
    chk("nbytes_after_rst", rx_log.size(), N9);
`ifndef MII_NET_TX_PAD_EN
    check_fcs_literal("fcs_after_rst", 9);
`endif

    // 20-byte frame: full width length vs. saturating 4-bit length.
    rx_log.delete();
    send(s20, 1'b0);
    wait_done("done_20");
    repeat (3) @(posedge clk); #1;
    chk("len_20", flen, N20);
`ifndef MII_NET_TX_PAD_EN
    chk("len_sat4", flen4, 15);
`endif
    chk("leftover_exp", exp_q.size(), 0);

    repeat (20) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
